// File: rtl/lc3b_types.sv
// Shared types for the LC-3b instruction fetch stage: the machine word,
// the fetch FSM encoding and the {pc, instruction} buffer entry.
package lc3b_types;

  typedef logic [15:0] lc3b_word;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    SQUASH = 2'd2
  } lc3b_fetch_state;

  typedef struct packed {
    lc3b_word pc;
    lc3b_word instr;
  } fetch_entry_t;

  localparam int unsigned FIFO_DEPTH = 2;
  localparam lc3b_word    RESET_PC   = 16'h0000;
  localparam lc3b_word    PC_STEP    = 16'h0002;

  // Instructions are word aligned, so a redirect target drops bit 0.
  function automatic lc3b_word align_pc(input lc3b_word pc);
    return pc & ~16'h0001;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Two-entry {pc, instruction} buffer between fetch and decode.
// Flush wins over push and pop; a simultaneous push and pop keeps order.
module fetch_fifo
  import lc3b_types::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic         i_flush,
  input  fetch_entry_t i_wdata,
  output fetch_entry_t o_head,
  output logic [1:0]   o_count
);

  fetch_entry_t r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_pop  = i_pop && (r_count != 2'd0);
  assign w_do_push = i_push && ((r_count != 2'd2) || w_do_pop);

  // Storage write; contents are qualified by r_count, so they need no reset.
  // NOTE: the data array is deliberately left out of reset - only the
  // pointers and count must be known, and an unreset array maps to plain RAM.
  always_ff @(posedge clk) begin
    if (w_do_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_flush) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_do_push) r_wr_ptr <= ~r_wr_ptr;
      if (w_do_pop)  r_rd_ptr <= ~r_rd_ptr;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/lc3b_fetch.sv
// LC-3b fetch stage: issues instruction reads at req_pc, buffers returned
// words for decode, and handles redirects (squashing any read in flight).
module lc3b_fetch
  import lc3b_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  output lc3b_word mem_address,
  output logic     mem_read,
  input  lc3b_word mem_rdata,
  input  logic     mem_resp,
  input  logic     redirect,
  input  lc3b_word redirect_pc,
  output logic     ir_load,
  output lc3b_word ir_data,
  output lc3b_word ir_pc,
  input  logic     ir_ready
);

  lc3b_fetch_state r_state;
  lc3b_word        r_req_pc;
  lc3b_word        r_next_pc;

  lc3b_fetch_state w_state_nxt;
  lc3b_word        w_req_pc_nxt;
  lc3b_word        w_target;
  logic            w_push;
  logic            w_pop;
  logic [1:0]      w_count;
  logic [1:0]      w_count_after;
  fetch_entry_t    w_head;
  fetch_entry_t    w_wdata;

  assign w_target      = align_pc(redirect_pc);
  assign w_pop         = ir_load && ir_ready;
  // Occupancy after this edge when a response is pushed in FETCH.
  assign w_count_after = w_count + 2'd1 - {1'b0, w_pop};
  assign w_wdata       = '{pc: r_req_pc, instr: mem_rdata};

  fetch_fifo u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata (w_wdata),
    .o_head  (w_head),
    .o_count (w_count)
  );

  // Next-state, next request address and push decision.
  // NOTE: every output of this block gets a default first so no path
  // leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_nxt  = r_state;
    w_req_pc_nxt = r_req_pc;
    w_push       = 1'b0;
    case (r_state)
      IDLE: begin
        if (redirect) begin
          w_req_pc_nxt = w_target;
          w_state_nxt  = FETCH;
        end else if (w_count < 2'd2) begin
          w_state_nxt  = FETCH;
        end
      end
      FETCH: begin
        if (redirect) begin
          if (mem_resp) w_req_pc_nxt = w_target;
          else          w_state_nxt  = SQUASH;
        end else if (mem_resp) begin
          w_push       = 1'b1;
          w_req_pc_nxt = r_req_pc + PC_STEP;
          w_state_nxt  = (w_count_after < 2'd2) ? FETCH : IDLE;
        end
      end
      SQUASH: begin
        if (mem_resp) begin
          w_req_pc_nxt = redirect ? w_target : r_next_pc;
          w_state_nxt  = FETCH;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM and request-address registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_req_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_nxt;
      r_req_pc <= w_req_pc_nxt;
    end
  end

  // Pending redirect target; the most recent redirect always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_next_pc <= RESET_PC;
    end else if (redirect) begin
      r_next_pc <= w_target;
    end
  end

  assign mem_read    = (r_state != IDLE);
  assign mem_address = r_req_pc;
  assign ir_load     = (w_count != 2'd0);
  assign ir_data     = w_head.instr;
  assign ir_pc       = w_head.pc;

endmodule

// File: tb/tb_lc3b_fetch.sv
// Self-checking bench for lc3b_fetch: directed scenarios plus a randomized
// phase, all compared against a queue-based reference model of the stage.
module tb_lc3b_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] mem_address;
  logic        mem_read;
  logic [15:0] mem_rdata;
  logic        mem_resp;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        ir_load;
  logic [15:0] ir_data;
  logic [15:0] ir_pc;
  logic        ir_ready;

  lc3b_fetch dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mem_address (mem_address),
    .mem_read    (mem_read),
    .mem_rdata   (mem_rdata),
    .mem_resp    (mem_resp),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .ir_load     (ir_load),
    .ir_data     (ir_data),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Reference model: a request is either absent, live, or being discarded.
  typedef struct { logic [15:0] pc; logic [15:0] instr; } ent_t;
  ent_t        m_q[$];
  bit          m_active;
  bit          m_discard;
  logic [15:0] m_req;
  logic [15:0] m_next;

  // Memory / decode environment knobs and observations.
  int          cfg_wait;
  int          ready_pct;
  int          wait_cnt;
  bit          force_resp;
  logic [15:0] acc_q[$];
  logic        obs_read, obs_load;
  logic [15:0] obs_addr, obs_pc;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_active  = 1'b0;
    m_discard = 1'b0;
    m_req     = 16'h0000;
    m_next    = 16'h0000;
  endtask

  task automatic model_update(input bit redir, input logic [15:0] rpc, input bit resp,
                              input logic [15:0] data, input bit rdy);
    int          pre_size;
    logic [15:0] tgt;
    pre_size = m_q.size();
    tgt      = rpc & 16'hFFFE;
    if (redir) begin
      m_q.delete();
      m_next = tgt;
      if (!m_active || resp) begin
        m_req     = tgt;
        m_active  = 1'b1;
        m_discard = 1'b0;
      end else begin
        m_discard = 1'b1;
      end
    end else begin
      if (pre_size > 0 && rdy) void'(m_q.pop_front());
      if (!m_active) begin
        if (pre_size < 2) m_active = 1'b1;
      end else if (resp) begin
        if (m_discard) begin
          m_req     = m_next;
          m_discard = 1'b0;
        end else begin
          m_q.push_back('{pc: m_req, instr: data});
          m_req = m_req + 16'd2;
          if (m_q.size() >= 2) m_active = 1'b0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("mem_read", {15'd0, mem_read}, {15'd0, m_active});
    chk("mem_address", mem_address, m_req);
    chk("ir_load", {15'd0, ir_load}, (m_q.size() != 0) ? 16'd1 : 16'd0);
    if (m_q.size() != 0) begin
      chk("ir_pc", ir_pc, m_q[0].pc);
      chk("ir_data", ir_data, m_q[0].instr);
    end
  endtask

  // One clock: called just after a falling edge, returns after the next one.
  task automatic do_cycle(input bit redir, input logic [15:0] rpc);
    bit          rdy;
    bit          resp;
    logic [15:0] data;
    check_outputs();
    obs_read = mem_read;
    obs_load = ir_load;
    obs_addr = mem_address;
    obs_pc   = ir_pc;
    rdy  = ($urandom_range(99) < ready_pct);
    resp = 1'b0;
    if (force_resp) begin
      resp = 1'b1;
    end else if (mem_read) begin
      if (wait_cnt >= cfg_wait) begin
        resp     = 1'b1;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    data = 16'($urandom);
    if (ir_load && rdy) acc_q.push_back(ir_pc);
    mem_resp    = resp;
    mem_rdata   = data;
    ir_ready    = rdy;
    redirect    = redir;
    redirect_pc = rpc;
    @(posedge clk);
    model_update(redir, rpc, resp, data, rdy);
    @(negedge clk);
  endtask

  // Asynchronous reset pulse taken away from any clock edge.
  task automatic pulse_reset();
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mem_read", {15'd0, mem_read}, 16'd0);
    chk("rst_ir_load", {15'd0, ir_load}, 16'd0);
    chk("rst_mem_address", mem_address, 16'h0000);
    model_reset();
    mem_resp = 1'b0;
    redirect = 1'b0;
    wait_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n       = 1'b0;
    mem_rdata   = 16'h0000;
    mem_resp    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0000;
    ir_ready    = 1'b0;
    force_resp  = 1'b0;
    wait_cnt    = 0;
    cfg_wait    = 0;
    ready_pct   = 100;
    model_reset();
    @(negedge clk);
    pulse_reset();

    // Zero-wait streaming with decode always ready.
    acc_q.delete();
    do_cycle(1'b0, 16'h0);
    chk("idle_after_reset", {15'd0, obs_read}, 16'd0);
    do_cycle(1'b0, 16'h0);
    chk("first_read", {15'd0, obs_read}, 16'd1);
    chk("first_addr", obs_addr, 16'h0000);
    repeat (4) begin
      do_cycle(1'b0, 16'h0);
      chk("load_continuous", {15'd0, obs_load}, 16'd1);
    end
    chk("stream_len", 16'(acc_q.size()), 16'd4);
    chk("stream_pc0", acc_q[0], 16'h0000);
    chk("stream_pc1", acc_q[1], 16'h0002);
    chk("stream_pc2", acc_q[2], 16'h0004);

    // Decode stalled: buffer fills to two, fetch idles, then drains in order.
    pulse_reset();
    ready_pct = 0;
    repeat (6) do_cycle(1'b0, 16'h0);
    chk("full_idle_read", {15'd0, obs_read}, 16'd0);
    chk("full_head_pc", obs_pc, 16'h0000);
    ready_pct = 100;
    acc_q.delete();
    repeat (4) do_cycle(1'b0, 16'h0);
    chk("drain_pc0", acc_q[0], 16'h0000);
    chk("drain_pc1", acc_q[1], 16'h0002);
    chk("drain_pc2", acc_q[2], 16'h0004);

    // Redirect to an odd target during the first wait cycle of a slow read.
    pulse_reset();
    cfg_wait = 3;
    acc_q.delete();
    do_cycle(1'b0, 16'h0);
    do_cycle(1'b1, 16'h3001);
    chk("squash_start_read", {15'd0, obs_read}, 16'd1);
    chk("squash_start_addr", obs_addr, 16'h0000);
    repeat (3) begin
      do_cycle(1'b0, 16'h0);
      chk("squash_hold_addr", obs_addr, 16'h0000);
      chk("squash_no_load", {15'd0, obs_load}, 16'd0);
    end
    do_cycle(1'b0, 16'h0);
    chk("post_squash_addr", obs_addr, 16'h3000);
    chk("post_squash_no_load", {15'd0, obs_load}, 16'd0);
    repeat (10) do_cycle(1'b0, 16'h0);
    chk("redirect_first_pc", acc_q[0], 16'h3000);

    // Redirect together with a response and a pop.
    pulse_reset();
    cfg_wait = 0;
    repeat (4) do_cycle(1'b0, 16'h0);
    do_cycle(1'b1, 16'h1234);
    chk("coincide_load", {15'd0, obs_load}, 16'd1);
    chk("coincide_read", {15'd0, obs_read}, 16'd1);
    do_cycle(1'b0, 16'h0);
    chk("coincide_empty", {15'd0, obs_load}, 16'd0);
    chk("coincide_addr", obs_addr, 16'h1234);

    // Address wrap at the top of memory.
    do_cycle(1'b1, 16'hFFFE);
    acc_q.delete();
    repeat (4) do_cycle(1'b0, 16'h0);
    chk("wrap_pc0", acc_q[0], 16'hFFFE);
    chk("wrap_pc1", acc_q[1], 16'h0000);

    // Reset in the middle of a request; a stale response afterwards is ignored.
    cfg_wait  = 3;
    ready_pct = 0;
    pulse_reset();
    repeat (6) do_cycle(1'b0, 16'h0);
    chk("pre_reset_busy", {15'd0, mem_read}, 16'd1);
    chk("pre_reset_load", {15'd0, ir_load}, 16'd1);
    pulse_reset();
    force_resp = 1'b1;
    do_cycle(1'b0, 16'h0);
    force_resp = 1'b0;
    chk("stale_resp_idle", {15'd0, obs_read}, 16'd0);
    do_cycle(1'b0, 16'h0);
    chk("restart_read", {15'd0, obs_read}, 16'd1);
    chk("restart_addr", obs_addr, 16'h0000);
    chk("restart_empty", {15'd0, obs_load}, 16'd0);

    // Reset with the buffer full.
    cfg_wait = 0;
    repeat (6) do_cycle(1'b0, 16'h0);
    chk("full_before_reset", {15'd0, ir_load}, 16'd1);
    pulse_reset();

    // Randomized traffic: varying latency, back-pressure and redirects.
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) begin
        cfg_wait  = $urandom_range(3);
        ready_pct = ($urandom_range(3) == 0) ? 0 : 30 + $urandom_range(70);
      end
      if ($urandom_range(299) == 0) begin
        pulse_reset();
      end else if ($urandom_range(11) == 0) begin
        do_cycle(1'b1, 16'($urandom));
      end else begin
        do_cycle(1'b0, 16'h0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
